// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcode constants, the canonical NOP and J-immediate decode.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Sign-extended JAL offset; bit 0 is always zero.
  function automatic logic [31:0] j_imm(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with a single-cycle flush.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign rd_data_o = mem_q[rd_ptr_q];

  // Flush wins over both push and pop so a redirect leaves the buffer empty.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) begin
          mem_q[wr_ptr_q] <= wr_data_i;
          wr_ptr_q        <= wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// RV32I instruction-fetch front end: PC register, imem address, fetch buffer to decode.
// Define IF_JAL_PREDICT_EN to follow JAL targets at fetch time instead of pc + 4.
module instr_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misalign_err
);

  logic [31:0] pc_q, pc_d, next_pc;
  logic        misalign_q, misalign_d;
  logic        enq, deq, fifo_full, fifo_empty;
  logic [63:0] head;

  assign imem_addr = pc_q;
  assign enq       = !fifo_full && !redirect_valid;
  assign deq       = !fifo_empty && out_ready && !redirect_valid;

`ifdef IF_JAL_PREDICT_EN
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (imem_instr[6:0] == OPC_JAL) begin
      next_pc = pc_q + j_imm(imem_instr);
    end
  end
`else
  assign next_pc = pc_q + 32'd4;
`endif

  // Redirect overrides any fetch advance; a misaligned target is realigned and flagged.
  always_comb begin
    pc_d       = pc_q;
    misalign_d = 1'b0;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      misalign_d = |redirect_pc[1:0];
    end else if (enq) begin
      pc_d = next_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (redirect_valid),
    .push_i    (enq),
    .wr_data_i ({pc_q, imem_instr}),
    .pop_i     (deq),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign out_valid    = !fifo_empty;
  assign out_pc       = head[63:32];
  assign out_instr    = head[31:0];
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized stream
// checked against an in-order fetch model driven by a behavioural instruction memory.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misalign_err;

  logic [31:0] mem [65536];
  int total = 0;
  int bad   = 0;

  instr_fetch #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .misalign_err   (misalign_err)
  );

  assign imem_instr = mem[imem_addr[17:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    return mem[a[17:2]];
  endfunction

  // Program-order successor of a fetch address, computed from the instruction encoding.
  function automatic logic [31:0] model_next(input logic [31:0] pc);
    logic [31:0] w;
    int          off;
    w = mem_at(pc);
`ifdef IF_JAL_PREDICT_EN
    if (w[6:0] == 7'b1101111) begin
      off = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
            + int'(w[30:21]) * 2;
      return pc + 32'(off);
    end
`else
    off = 0;
    if (w[6:0] == 7'b1101111 && off != 0) return pc;
`endif
    return pc + 32'd4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    rst            = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", out_pc); end
    total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=0", out_instr); end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%0b want=0", misalign_err); end
    total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL reset_addr got=%h want=%h", imem_addr, RESET_PC); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    rst = 1'b0;
    out_ready = 1'b1;
    exp_pc = RESET_PC;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_first_valid got=%0b want=0", out_valid); end
    for (int i = 0; i < 8; i++) begin
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%0b want=1", i, out_valid); end
      total++; if (out_pc !== exp_pc) begin bad++; $display("FAIL stream_pc[%0d] got=%h want=%h", i, out_pc, exp_pc); end
      total++; if (out_instr !== mem_at(exp_pc)) begin bad++; $display("FAIL stream_instr[%0d] got=%h want=%h", i, out_instr, mem_at(exp_pc)); end
      exp_pc = model_next(exp_pc);
    end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin bad++; $display("FAIL stall_hold[%0d] got=%0b/%h want=1/0", i, out_valid, out_pc); end
    end
    total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL stall_addr got=%h want=8", imem_addr); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * i)) begin bad++; $display("FAIL stall_drain[%0d] got=%0b/%h want=1/%h", i, out_valid, out_pc, 32'(4 * i)); end
      tick();
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    out_ready = 1'b0;
    tick(); tick(); tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0040;
    tick();
    redirect_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_valid got=%0b want=0", out_valid); end
    total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL redir_addr got=%h want=40", imem_addr); end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL redir_misalign got=%0b want=0", misalign_err); end
    tick();
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin bad++; $display("FAIL redir_head got=%0b/%h want=1/40", out_valid, out_pc); end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL redir_misalign2 got=%0b want=0", misalign_err); end
  endtask

  task automatic test_misalign();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0042;
    tick();
    redirect_valid = 1'b0;
    total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL mis_pulse got=%0b want=1", misalign_err); end
    total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL mis_addr got=%h want=40", imem_addr); end
    tick();
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL mis_clear got=%0b want=0", misalign_err); end
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin bad++; $display("FAIL mis_head got=%0b/%h want=1/40", out_valid, out_pc); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    redirect_pc = 32'h0000_0204;
    tick();
    redirect_valid = 1'b0;
    total++; if (imem_addr !== 32'h204 || out_valid !== 1'b0) begin bad++; $display("FAIL b2b_addr got=%h/%0b want=204/0", imem_addr, out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h204) begin bad++; $display("FAIL b2b_head got=%0b/%h want=1/204", out_valid, out_pc); end
    out_ready = 1'b0;
    tick(); tick();
    a = imem_addr;
    redirect_valid = 1'b1;
    redirect_pc = a;
    tick();
    redirect_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || imem_addr !== a) begin bad++; $display("FAIL self_flush got=%0b/%h want=0/%h", out_valid, imem_addr, a); end
    tick();
    total++; if (out_valid !== 1'b1 || out_pc !== a) begin bad++; $display("FAIL self_head got=%0b/%h want=1/%h", out_valid, out_pc, a); end
  endtask

  task automatic test_jal();
    logic [31:0] want;
`ifdef IF_JAL_PREDICT_EN
    want = 32'h0000_6070;
`else
    want = 32'h0000_0070;
`endif
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_006C;
    tick();
    redirect_valid = 1'b0;
    tick();
    total++; if (out_pc !== 32'h6C || out_instr !== 32'h0040_606F) begin bad++; $display("FAIL jal_entry got=%h/%h want=6c/0040606f", out_pc, out_instr); end
    tick();
    total++; if (out_valid !== 1'b1 || out_pc !== want) begin bad++; $display("FAIL jal_target got=%0b/%h want=1/%h", out_valid, out_pc, want); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, held_pc, held_instr, tgt;
    logic        redir, held, exp_mis;
    do_reset();
    exp_pc = RESET_PC;
    for (int i = 0; i < 400; i++) begin
      redir = ($urandom_range(0, 15) == 0);
      tgt = $urandom & 32'h0003_FFFF;
      if ($urandom_range(0, 3) == 0) tgt = 32'h0000_006C;
      out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = redir;
      redirect_pc = tgt;
      held = out_valid && !out_ready && !redir;
      held_pc = out_pc;
      held_instr = out_instr;
      exp_mis = redir && (tgt % 4 != 0);
      if (redir) begin
        exp_pc = tgt & ~32'h3;
      end else if (out_valid && out_ready) begin
        total++; if (out_pc !== exp_pc || out_instr !== mem_at(exp_pc)) begin bad++; $display("FAIL rnd_accept[%0d] got=%h/%h want=%h/%h", i, out_pc, out_instr, exp_pc, mem_at(exp_pc)); end
        exp_pc = model_next(exp_pc);
      end
      tick();
      total++; if (misalign_err !== exp_mis) begin bad++; $display("FAIL rnd_misalign[%0d] got=%0b want=%0b", i, misalign_err, exp_mis); end
      total++; if (out_valid !== !redir) begin bad++; $display("FAIL rnd_valid[%0d] got=%0b want=%0b", i, out_valid, !redir); end
      if (held) begin
        total++; if (out_pc !== held_pc || out_instr !== held_instr) begin bad++; $display("FAIL rnd_hold[%0d] got=%h/%h want=%h/%h", i, out_pc, out_instr, held_pc, held_instr); end
      end
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    out_ready = 1'b0;
    tick(); tick(); tick();
    #3;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0b want=0", out_valid); end
    total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL midrst_addr got=%h want=%h", imem_addr, RESET_PC); end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1 || out_pc !== RESET_PC) begin bad++; $display("FAIL midrst_restart got=%0b/%h want=1/%h", out_valid, out_pc, RESET_PC); end
    tick();
    total++; if (out_pc !== RESET_PC + 32'd4) begin bad++; $display("FAIL midrst_next got=%h want=%h", out_pc, RESET_PC + 32'd4); end
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    for (int i = 0; i < 65536; i++) begin
      w = $urandom;
      if (w[6:0] == 7'b1101111) w[6:0] = 7'b0010011;
      mem[i] = w;
    end
    mem[0]  = 32'h003100B3;
    mem[27] = 32'h0040606F;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_misalign();
    test_back_to_back();
    test_jal();
    test_random();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

- Instruction-fetch front end of the RV32I core.
- Drives the word address into the combinational instruction memory and captures the returned instruction together with its PC.
- Buffers fetched pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Sits between the PC/branch-resolution logic (redirect input) and the decode stage.

## Interface

- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- FIFO_DEPTH, 2, fetch-buffer entries; power of two, ≥2.
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  32  byte address to instruction memory; the memory indexes with addr[17:2].
- imem_instr  in  32  instruction returned combinationally for imem_addr.
- redirect_valid  in  1  flush the pipeline and restart at redirect_pc.
- redirect_pc  in  32  new fetch address.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  32  head instruction.
- out_pc  out  32  head PC.
- misalign_err  out  1  one-cycle pulse: redirect_pc[1:0] was nonzero.

## Operation

- pc register. imem_addr = pc at all times.
- Enqueue each cycle when count < FIFO_DEPTH and redirect_valid = 0:
  - push {pc, imem_instr};
  - pc <= next_pc.
- next_pc = pc + 4. Wraps modulo 2^32; no overflow flag.
- Dequeue when out_valid && out_ready. Enqueue and dequeue in the same cycle are both allowed; count is unchanged.
- Redirect has top priority in its cycle:
  - count <= 0; all entries discarded; no enqueue.
  - Any dequeue handshake that cycle is ignored by the block; decode must also drop on redirect.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - misalign_err <= |redirect_pc[1:0].
- Back-to-back redirects: the last one wins. A redirect to the current pc still flushes.
- When full and out_ready = 0: pc holds and imem_addr is stable.

## Timing

- Reset values: pc = RESET_PC, count = 0, out_valid = 0, out_instr = 0, out_pc = 0, misalign_err = 0.
- A reset asserted mid-operation takes effect asynchronously. Held FIFO contents are discarded.
- Fetch latency: an instruction at pc appears at the FIFO head the cycle after capture, with out_valid = 1.
- Redirect latency: redirect in cycle N.
  - Cycle N+1: imem_addr = redirect_pc, out_valid = 0.
  - Cycle N+2: out_valid = 1 with out_pc = redirect_pc.
- Throughput: one instruction per cycle sustained while out_ready = 1.
- out_valid depends only on registered state; no combinational path from out_ready.
- out_valid, out_instr and out_pc stay stable while out_valid && !out_ready.

## Configuration

- IF_JAL_PREDICT_EN defined:
  - If captured imem_instr[6:0] = 7'b1101111 (JAL), next_pc = pc + sext(J-immediate).
  - The entry is still enqueued unchanged.
  - Redirect still overrides.
- IF_JAL_PREDICT_EN undefined: next_pc is always pc + 4, and the J-immediate logic is not built.

## Structure

- Shared package rv32i_pkg holds:
  - opcode constants (OPC_JAL = 7'b1101111 and the rest);
  - the NOP constant 32'h0000_0013;
  - the J-immediate extraction function.
- One sub-module: fetch_fifo, a parameterised synchronous FIFO with a flush input, storing 64-bit {pc, instr} entries with count-based full/empty.
- The PC and next-PC logic stays in instr_fetch.

## Test plan

- Reset release with memory[0] = 32'h003100B3 and out_ready = 1:
  - next cycle out_valid = 1, out_pc = 0, out_instr = 32'h003100B3;
  - then out_pc = 4, 8, ... each cycle.
- out_ready = 0 for 5 cycles:
  - count saturates at 2 and imem_addr holds at 8;
  - releasing out_ready yields out_pc 0, 4, 8 in order with no gaps.
- Redirect to 32'h0000_0040 while full:
  - next cycle out_valid = 0, imem_addr = 32'h40;
  - following cycle out_pc = 32'h40;
  - misalign_err stays 0.
- Redirect to 32'h0000_0042: misalign_err pulses one cycle, and fetch resumes at 32'h40.
- With IF_JAL_PREDICT_EN, JAL 32'h0040_606F at 32'h6C: the entry after out_pc = 32'h6C has out_pc = 32'h6070. Without the macro it has out_pc = 32'h70.
- Assert rst mid-stream with count = 2: out_valid drops immediately, and after release fetch restarts at RESET_PC.
